hs_stream_join: RTL and testbench



---
 rtl/hs_stream_join_pkg.sv | 23 ++
 rtl/hs_stream_join_if.sv | 41 ++++
 rtl/hs_sync_fifo.sv | 52 +++++
 rtl/hs_stream_join.sv | 132 +++++++++++++
 tb/tb_hs_stream_join.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hs_stream_join_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hs_stream_pkg
// Description : Shared beat type and sizing helpers for the stream join path.
// Revision    : 1.0 - initial release
// ============================================================================
package hs_stream_pkg;

    localparam int BEAT_DATA_W = 8;

    // One joined beat at the default data width: {last, data}.
    typedef struct packed {
        logic                   last;
        logic [BEAT_DATA_W-1:0] data;
    } beat_t;

    // Width of the beat index counter; a one-beat frame still needs one bit.
    function automatic int idx_width(input int frame_len);
        return (frame_len <= 1) ? 1 : $clog2(frame_len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hs_stream_join_if.sv
`default_nettype none
// ============================================================================
// Module      : hs_stream_join_if
// Description : Kernel ap_hs value/last channels plus the joined output stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface hs_stream_join_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] hw_output_V_value_V;
    logic              hw_output_V_value_V_ap_vld;
    logic              hw_output_V_value_V_ap_ack;
    logic              hw_output_V_last_V;
    logic              hw_output_V_last_V_ap_vld;
    logic              hw_output_V_last_V_ap_ack;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;

    // Join block view: consumes the kernel channels, sources the stream.
    modport slave (
        input  hw_output_V_value_V, hw_output_V_value_V_ap_vld,
        output hw_output_V_value_V_ap_ack,
        input  hw_output_V_last_V, hw_output_V_last_V_ap_vld,
        output hw_output_V_last_V_ap_ack,
        output m_data, m_last, m_valid,
        input  m_ready
    );

    // Kernel and downstream sink view.
    modport master (
        output hw_output_V_value_V, hw_output_V_value_V_ap_vld,
        input  hw_output_V_value_V_ap_ack,
        output hw_output_V_last_V, hw_output_V_last_V_ap_vld,
        input  hw_output_V_last_V_ap_ack,
        input  m_data, m_last, m_valid,
        output m_ready
    );
endinterface
`default_nettype wire

// File: rtl/hs_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : hs_sync_fifo
// Description : First-word fall-through synchronous FIFO, power-of-two depth.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             wr_en,
    input  wire logic [WIDTH-1:0] wr_data,
    input  wire logic             rd_en,
    output logic      [WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_wr  = wr_en & ~full;
    assign w_rd  = rd_en & ~empty;

    // Head reads as zero while empty so the output is clean out of reset.
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[PTR_W-1:0]] <= wr_data;
    end
endmodule
`default_nettype wire

// File: rtl/hs_stream_join.sv
`default_nettype none
// ============================================================================
// Module      : hs_stream_join
// Description : Joins ap_hs value/last channels into one FIFO-buffered stream
//               with frame-length checking and a completed-frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_stream_join #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_LEN  = 10,
    parameter int CNT_W      = 16
) (
    input  wire logic             ap_clk,
    input  wire logic             ap_rst,
    hs_stream_join_if.slave       bus,
    output logic      [CNT_W-1:0] frame_count,
    output logic                  frame_done,
    output logic                  err_early,
    output logic                  err_missing
);
    import hs_stream_pkg::*;

    localparam int               IDX_W    = idx_width(FRAME_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } join_beat_t;

    logic [DATA_W-1:0] r_value;
    logic              r_value_held;
    logic              r_last;
    logic              r_last_held;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_frame_count;
    logic              r_frame_done;
    logic              r_err_early;
    logic              r_err_missing;

    logic              w_push;
    logic              w_value_ack;
    logic              w_last_ack;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    join_beat_t        w_wr_beat;
    join_beat_t        w_rd_beat;

    // Full is the pre-pop status, so a pop never feeds back into the acks.
    assign w_push      = ~ap_rst & r_value_held & r_last_held & ~w_fifo_full;
    assign w_value_ack = ~ap_rst & bus.hw_output_V_value_V_ap_vld & (~r_value_held | w_push);
    assign w_last_ack  = ~ap_rst & bus.hw_output_V_last_V_ap_vld  & (~r_last_held  | w_push);

    assign bus.hw_output_V_value_V_ap_ack = w_value_ack;
    assign bus.hw_output_V_last_V_ap_ack  = w_last_ack;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_value      <= '0;
            r_value_held <= 1'b0;
            r_last       <= 1'b0;
            r_last_held  <= 1'b0;
        end else begin
            // A capture in the same cycle as a push refills the slot.
            if (w_value_ack) begin
                r_value      <= bus.hw_output_V_value_V;
                r_value_held <= 1'b1;
            end else if (w_push) begin
                r_value_held <= 1'b0;
            end
            if (w_last_ack) begin
                r_last      <= bus.hw_output_V_last_V;
                r_last_held <= 1'b1;
            end else if (w_push) begin
                r_last_held <= 1'b0;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_idx         <= '0;
            r_frame_count <= '0;
            r_frame_done  <= 1'b0;
            r_err_early   <= 1'b0;
            r_err_missing <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_push) begin
                if (r_idx == IDX_LAST) begin
                    // Frame closes at the expected length whatever last says.
                    r_idx         <= '0;
                    r_frame_count <= r_frame_count + CNT_W'(1);
                    r_frame_done  <= 1'b1;
                    if (!r_last) r_err_missing <= 1'b1;
                end else if (r_last) begin
                    r_idx       <= '0;
                    r_err_early <= 1'b1;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign w_wr_beat = '{last: r_last, data: r_value};

    hs_sync_fifo #(
        .WIDTH ($bits(join_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .wr_en   (w_push),
        .wr_data (w_wr_beat),
        .rd_en   (bus.m_ready),
        .rd_data (w_rd_beat),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    assign bus.m_valid = ~w_fifo_empty;
    assign bus.m_data  = w_rd_beat.data;
    assign bus.m_last  = w_rd_beat.last;

    assign frame_count = r_frame_count;
    assign frame_done  = r_frame_done;
    assign err_early   = r_err_early;
    assign err_missing = r_err_missing;
endmodule
`default_nettype wire

// File: tb/tb_hs_stream_join.sv
`default_nettype none
// ============================================================================
// Module      : tb_hs_stream_join
// Description : Scoreboard bench for hs_stream_join (DATA_W=8, FRAME_LEN=10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_stream_join;
    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic [15:0] frame_count;
    logic        frame_done;
    logic        err_early;
    logic        err_missing;

    always #5 ap_clk = ~ap_clk;

    hs_stream_join_if #(.DATA_W(8)) bus ();

    hs_stream_join #(
        .DATA_W     (8),
        .FIFO_DEPTH (4),
        .FRAME_LEN  (10),
        .CNT_W      (16)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .bus         (bus.slave),
        .frame_count (frame_count),
        .frame_done  (frame_done),
        .err_early   (err_early),
        .err_missing (err_missing)
    );

    int         checks = 0;
    int         errors = 0;
    int         out_cnt = 0;
    int         done_cnt = 0;
    int         v_xfer = 0;
    int         l_xfer = 0;
    bit         stream_done = 1'b0;
    logic [8:0] exp_q [$];
    logic [8:0] mon_e;
    logic [7:0] vals  [16];
    logic       lasts [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Output side: pop the scoreboard on every accepted beat.
    always @(negedge ap_clk) begin
        if (!ap_rst) begin
            if (bus.m_valid && bus.m_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_data", bus.m_data, mon_e[7:0]);
                    check("beat_last", bus.m_last, mon_e[8]);
                end
            end
            if (frame_done) done_cnt++;
            if (bus.hw_output_V_value_V_ap_vld && bus.hw_output_V_value_V_ap_ack) v_xfer++;
            if (bus.hw_output_V_last_V_ap_vld && bus.hw_output_V_last_V_ap_ack) l_xfer++;
        end
    end

    task automatic set_vld(input int ch, input logic v);
        if (ch == 0) bus.hw_output_V_value_V_ap_vld = v;
        else         bus.hw_output_V_last_V_ap_vld  = v;
    endtask

    // Drives one ap_hs channel for beats [from,to); lag idles it before each beat.
    task automatic send_chan(input int ch, input int from, input int to, input int lag);
        for (int i = from; i < to; i++) begin
            int   cnt;
            logic got;
            if (lag > 0) begin
                set_vld(ch, 1'b0);
                repeat (lag) @(posedge ap_clk);
                #1;
            end
            if (ch == 0) bus.hw_output_V_value_V = vals[i];
            else         bus.hw_output_V_last_V  = lasts[i];
            set_vld(ch, 1'b1);
            cnt = 0;
            got = 1'b0;
            while (!got && cnt < 200) begin
                @(negedge ap_clk);
                got = (ch == 0) ? bus.hw_output_V_value_V_ap_ack : bus.hw_output_V_last_V_ap_ack;
                @(posedge ap_clk);
                cnt++;
            end
            if (!got) check((ch == 0) ? "value_ack_timeout" : "last_ack_timeout", 0, 1);
            #1;
        end
        set_vld(ch, 1'b0);
    endtask

    task automatic run_stream(input int from, input int to, input int lag);
        stream_done = 1'b0;
        for (int i = from; i < to; i++) exp_q.push_back({lasts[i], vals[i]});
        fork
            send_chan(0, from, to, 0);
            send_chan(1, from, to, lag);
        join
        stream_done = 1'b1;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge ap_clk);
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (3) @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b1;
        bus.hw_output_V_value_V_ap_vld = 1'b1;
        bus.hw_output_V_last_V_ap_vld  = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        check("rst_value_ack", bus.hw_output_V_value_V_ap_ack, 0);
        check("rst_last_ack", bus.hw_output_V_last_V_ap_ack, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_m_last", bus.m_last, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err_early", err_early, 0);
        check("rst_err_missing", err_missing, 0);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        bus.hw_output_V_value_V_ap_vld = 1'b0;
        bus.hw_output_V_last_V_ap_vld  = 1'b0;
        exp_q.delete();
        out_cnt  = 0;
        done_cnt = 0;
        v_xfer   = 0;
        l_xfer   = 0;
    endtask

    task automatic load_frame(input int base, input int step, input int last_at);
        for (int i = 0; i < 16; i++) begin
            vals[i]  = 8'(base + step * i);
            lasts[i] = (i == last_at);
        end
    endtask

    initial begin
        bus.hw_output_V_value_V        = '0;
        bus.hw_output_V_value_V_ap_vld = 1'b0;
        bus.hw_output_V_last_V         = 1'b0;
        bus.hw_output_V_last_V_ap_vld  = 1'b0;
        bus.m_ready                    = 1'b1;
        do_reset();

        // Clean frame 50..95; first beat also probes the two-edge latency.
        load_frame(50, 5, 9);
        bus.m_ready = 1'b0;
        exp_q.push_back({lasts[0], vals[0]});
        bus.hw_output_V_value_V        = vals[0];
        bus.hw_output_V_last_V         = lasts[0];
        bus.hw_output_V_value_V_ap_vld = 1'b1;
        bus.hw_output_V_last_V_ap_vld  = 1'b1;
        @(negedge ap_clk);
        check("lat_value_ack", bus.hw_output_V_value_V_ap_ack, 1);
        check("lat_last_ack", bus.hw_output_V_last_V_ap_ack, 1);
        @(posedge ap_clk);
        #1;
        bus.hw_output_V_value_V_ap_vld = 1'b0;
        bus.hw_output_V_last_V_ap_vld  = 1'b0;
        @(negedge ap_clk);
        check("lat_valid_e0", bus.m_valid, 0);
        @(posedge ap_clk);
        @(negedge ap_clk);
        check("lat_valid_e1", bus.m_valid, 1);
        @(posedge ap_clk);
        #1;
        bus.m_ready = 1'b1;
        run_stream(1, 10, 0);
        wait_drain();
        check("t1_out_cnt", out_cnt, 10);
        check("t1_frame_count", frame_count, 1);
        check("t1_done_pulses", done_cnt, 1);
        check("t1_err_early", err_early, 0);
        check("t1_err_missing", err_missing, 0);

        // Backpressure: FIFO plus one held pair, then both acks stall.
        do_reset();
        load_frame(100, 1, 9);
        bus.m_ready = 1'b0;
        fork
            run_stream(0, 10, 0);
        join_none
        repeat (20) @(posedge ap_clk);
        #1;
        check("bp_value_xfer", v_xfer, 5);
        check("bp_last_xfer", l_xfer, 5);
        @(negedge ap_clk);
        check("bp_value_ack_low", bus.hw_output_V_value_V_ap_ack, 0);
        check("bp_last_ack_low", bus.hw_output_V_last_V_ap_ack, 0);
        @(posedge ap_clk);
        #1;
        bus.m_ready = 1'b1;
        for (int n = 0; n < 300 && !stream_done; n++) @(posedge ap_clk);
        check("bp_stream_done", stream_done, 1);
        wait_drain();
        check("bp_out_cnt", out_cnt, 10);
        check("bp_value_xfer_total", v_xfer, 10);
        check("bp_frame_count", frame_count, 1);

        // Last channel lags the value channel every beat.
        do_reset();
        load_frame(200, 1, 9);
        run_stream(0, 10, 3);
        wait_drain();
        check("lag_out_cnt", out_cnt, 10);
        check("lag_frame_count", frame_count, 1);
        check("lag_err_early", err_early, 0);
        check("lag_err_missing", err_missing, 0);

        // Early last at index 3, then a clean frame must start at index 0.
        do_reset();
        load_frame(1, 1, 3);
        for (int i = 4; i < 14; i++) begin
            vals[i]  = 8'(30 + i);
            lasts[i] = (i == 13);
        end
        run_stream(0, 4, 0);
        wait_drain();
        check("early_err_early", err_early, 1);
        check("early_frame_count", frame_count, 0);
        check("early_done_pulses", done_cnt, 0);
        run_stream(4, 14, 0);
        wait_drain();
        check("early_next_frame_count", frame_count, 1);
        check("early_next_err_missing", err_missing, 0);
        check("early_next_done_pulses", done_cnt, 1);

        // Ten beats without last.
        do_reset();
        load_frame(70, 2, -1);
        run_stream(0, 10, 0);
        wait_drain();
        check("miss_err_missing", err_missing, 1);
        check("miss_err_early", err_early, 0);
        check("miss_frame_count", frame_count, 1);
        check("miss_done_pulses", done_cnt, 1);

        // Reset mid-frame with beats parked in the FIFO.
        do_reset();
        load_frame(150, 3, 9);
        bus.m_ready = 1'b0;
        run_stream(0, 4, 0);
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        check("mid_m_valid_before", bus.m_valid, 1);
        do_reset();
        bus.m_ready = 1'b1;
        run_stream(0, 10, 0);
        wait_drain();
        check("mid_out_cnt", out_cnt, 10);
        check("mid_frame_count", frame_count, 1);
        check("mid_err_early", err_early, 0);
        check("mid_err_missing", err_missing, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
